tx_fifo_feeder: RTL and testbench
=================================

// Module: tx_fifo_feeder
// PURPOSE
//   Byte FIFO plus send sequencer sitting directly upstream of the UART transmitter (tx_module_3).
//   Accepts bytes from any producer via a single-cycle write strobe and buffers them.
//   Drains bytes one at a time into the transmitter using its tx_en_sig/tx_data/tx_done handshake.
//   Replaces hard-coded send sequences; producers no longer wait on the serial line.
// PARAMETERS
//   DEPTH_LOG2  4  log2 of FIFO depth (DEPTH = 16 entries); byte held in tx_data is not counted
// PORTS
//   clk        in   1             system clock; all logic on rising edge
//   rst_n      in   1             asynchronous, active-low reset
//   wr_en      in   1             push strobe; wr_data written on the rising edge while high
//   wr_data    in   8             byte to push
//   full       out  1             FIFO holds DEPTH entries
//   empty      out  1             FIFO holds 0 entries
//   count      out  DEPTH_LOG2+1  number of entries in FIFO, 0..DEPTH
//   overflow   out  1             1-clk pulse: wr_en while full (byte dropped)
//   tx_en_sig  out  1             to transmitter: high = send tx_data
//   tx_data    out  8             to transmitter: byte being sent, stable while tx_en_sig=1
//   tx_done    in   1             from transmitter: 1-clk pulse, byte fully shifted out
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=IDLE, pointers=0, count=0,
//     tx_en_sig=0, tx_data=8'h00, overflow=0, empty=1, full=0. FIFO memory is not cleared.
//   Storage: DEPTH x 8 register array; wr_ptr/rd_ptr are DEPTH_LOG2 bits and wrap modulo DEPTH.
//   count is a registered value. empty=(count==0) and full=(count==DEPTH), both decoded from registered count.
//   Push: wr_en & ~full -> mem[wr_ptr]<=wr_data, wr_ptr++.
//     wr_en & full -> no write; overflow=1 for the next clock only.
//   Pop: occurs only on IDLE->SEND; rd_ptr++.
//   Simultaneous push and pop: both occur; count unchanged.
//     Push while full and pop in the same cycle: push is still rejected (full is evaluated pre-edge).
//   FSM (2 states):
//     IDLE: tx_en_sig=0.
//       If ~empty: tx_data<=mem[rd_ptr], pop, tx_en_sig<=1, goto SEND.
//       Otherwise stay in IDLE. tx_done is ignored in IDLE.
//     SEND: tx_en_sig=1; tx_data is held constant.
//       On tx_done: tx_en_sig<=0, goto IDLE.
//   Inter-byte gap: tx_en_sig is low for exactly 1 clk between consecutive bytes when the FIFO is non-empty.
//   Latency: wr_en at edge N into an empty FIFO while IDLE -> count=1 after N, tx_en_sig=1 after edge N+1.
//   tx_data keeps its last value after tx_done (it is not cleared).
//   Reset mid-SEND: tx_en_sig drops immediately and buffered bytes are lost.
//     A tx_done arriving after reset release, while in IDLE, is ignored.
//   Total capacity with the transmitter busy: DEPTH+1 bytes (1 in tx_data + DEPTH in FIFO).
// TESTING
//   1. Assert reset, then release -> tx_en_sig=0, tx_data=00, count=0, empty=1, full=0, overflow=0.
//   2. Push 55,AA,BF on consecutive clks; transmitter model pulses tx_done 10 clks after tx_en_sig rises
//      -> tx_data sequence 55,AA,BF; tx_en_sig low exactly 1 clk between bytes; count ends at 0.
//   3. Hold tx_done=0 and push 18 bytes 00..11
//      -> tx_data=00, count=16, full=1 after the 17th push; 18th push gives a single overflow pulse
//         and count stays 16.
//   4. Preload count=5 with transmitter in SEND; on the clk tx_done pulses (IDLE->SEND next clk)
//      also assert wr_en -> count stays 5; order is preserved.
//   5. Assert rst_n mid-SEND with count=3 -> tx_en_sig=0, count=0 immediately.
//      A tx_done pulse after release causes no state change.
//   6. Pulse tx_done while IDLE and empty -> no effect.
//      Stream 40 bytes 0..39 through (pointer wrap) -> output order is 0..39 with no loss.

Source files
------------

// File: rtl/tx_fifo_feeder.sv
// Byte FIFO and send sequencer that feeds a UART transmitter through the
// tx_en_sig / tx_data / tx_done handshake, one byte at a time.
module tx_fifo_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_en_sig,
  output logic [7:0]            tx_data,
  input  logic                  tx_done
);
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push, pop;

  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  // full is the pre-edge value, so a push while full is rejected even if a pop happens
  assign push      = wr_en & ~full;
  assign tx_en_sig = (state == SEND);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // storage is not reset; only the pointers/count define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      overflow <= wr_en & full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Directed bench for tx_fifo_feeder with a simple transmitter model.
module tb_tx_fifo_feeder;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx_en_sig, tx_done = 1'b0;
  logic [4:0] count;
  logic [7:0] tx_data;

  int n_cmp = 0;
  int n_bad = 0;

  tx_fifo_feeder #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_en_sig(tx_en_sig), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    wr_en = 0; tx_done = 0; rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // Runs producer + transmitter model until nexp bytes have been sent and tx_en_sig is low.
  task automatic stream(input bq_t src, input int nexp, input int delay,
                        output bq_t got, output int gaps_bad, output bit tout);
    int idx = 0, cnt = 0, gap = 0;
    bit prev = 0, started = 0;
    got = {}; gaps_bad = 0; tout = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (tx_en_sig && !prev) begin
        got.push_back(tx_data);
        if (started && gap != 1) gaps_bad++;
        started = 1; cnt = 0; gap = 0;
      end
      if (!tx_en_sig) gap++;
      prev = tx_en_sig;
      tx_done = 0;
      if (tx_en_sig) begin
        cnt++;
        if (cnt == delay) tx_done = 1;
      end
      wr_en = 0;
      if (idx < src.size() && !full) begin
        wr_en = 1; wr_data = src[idx]; idx++;
      end
      if (got.size() >= nexp && !tx_en_sig && idx >= src.size()) begin
        tout = 0;
        break;
      end
      tick();
    end
    wr_en = 0; tx_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; wr_en = 0; tx_done = 0;
    tick();
    n_cmp++; if (tx_en_sig !== 1'b0) begin n_bad++; $display("FAIL rst_tx_en_in_reset got=%0b exp=0", tx_en_sig); end
    rst_n = 1;
    tick();
    n_cmp++; if (tx_en_sig !== 1'b0) begin n_bad++; $display("FAIL rst_tx_en got=%0b exp=0", tx_en_sig); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rst_flags empty=%0b full=%0b exp 1/0", empty, full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_basic_send();
    bq_t src, got;
    int gb; bit to;
    do_reset();
    src = '{8'h55, 8'hAA, 8'hBF};
    stream(src, 3, 10, got, gb, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout got=timeout exp=done"); end
    n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL basic_nbytes got=%0d exp=3", got.size()); end
    else begin
      n_cmp++; if (got[0] !== 8'h55 || got[1] !== 8'hAA || got[2] !== 8'hBF) begin
        n_bad++; $display("FAIL basic_order got=%h,%h,%h exp=55,aa,bf", got[0], got[1], got[2]); end
    end
    n_cmp++; if (gb != 0) begin n_bad++; $display("FAIL basic_gap got=%0d bad gaps exp=0", gb); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL basic_count_end got=%0d exp=0", count); end
  endtask

  task automatic test_full_overflow();
    bq_t got, none;
    int gb; bit to;
    do_reset();
    none = {};
    for (int i = 0; i < 17; i++) begin
      wr_en = 1; wr_data = 8'(i);
      tick();
    end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL full_count got=%0d exp=16", count); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag got=%0b exp=1", full); end
    n_cmp++; if (tx_data !== 8'h00 || tx_en_sig !== 1'b1) begin n_bad++; $display("FAIL full_txdata got=%h/%0b exp=00/1", tx_data, tx_en_sig); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_no_ovf got=%0b exp=0", overflow); end
    wr_data = 8'h11;
    tick();
    wr_en = 0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse got=%0b exp=1", overflow); end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    tick();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_single got=%0b exp=0", overflow); end
    stream(none, 17, 4, got, gb, to);
    n_cmp++; if (to || got.size() != 17) begin n_bad++; $display("FAIL full_drain_n got=%0d exp=17", got.size()); end
    else begin
      for (int i = 0; i < 17; i++) begin
        n_cmp++; if (got[i] !== 8'(i)) begin n_bad++; $display("FAIL full_drain_byte%0d got=%h exp=%h", i, got[i], 8'(i)); end
      end
    end
  endtask

  task automatic test_simul_push_pop();
    bq_t got, none;
    int gb; bit to;
    do_reset();
    none = {};
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; wr_data = 8'hA0 + 8'(i);
      tick();
    end
    wr_en = 0;
    n_cmp++; if (count !== 5'd5 || tx_data !== 8'hA0) begin n_bad++; $display("FAIL pp_preload count=%0d data=%h exp=5/a0", count, tx_data); end
    tx_done = 1;
    tick();
    tx_done = 0;
    n_cmp++; if (tx_en_sig !== 1'b0 || count !== 5'd5) begin n_bad++; $display("FAIL pp_idle en=%0b count=%0d exp=0/5", tx_en_sig, count); end
    wr_en = 1; wr_data = 8'hA6;
    tick();
    wr_en = 0;
    n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL pp_count got=%0d exp=5", count); end
    n_cmp++; if (tx_en_sig !== 1'b1 || tx_data !== 8'hA1) begin n_bad++; $display("FAIL pp_send en=%0b data=%h exp=1/a1", tx_en_sig, tx_data); end
    stream(none, 6, 3, got, gb, to);
    n_cmp++; if (to || got.size() != 6) begin n_bad++; $display("FAIL pp_drain_n got=%0d exp=6", got.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (got[i] !== 8'hA1 + 8'(i)) begin n_bad++; $display("FAIL pp_order%0d got=%h exp=%h", i, got[i], 8'hA1 + 8'(i)); end
      end
    end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_en = 0;
    n_cmp++; if (count !== 5'd3 || tx_en_sig !== 1'b1) begin n_bad++; $display("FAIL mid_pre count=%0d en=%0b exp=3/1", count, tx_en_sig); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (tx_en_sig !== 1'b0 || count !== 5'd0) begin n_bad++; $display("FAIL mid_async en=%0b count=%0d exp=0/0", tx_en_sig, count); end
    tick();
    rst_n = 1;
    tick();
    tx_done = 1;
    tick();
    tx_done = 0;
    tick();
    n_cmp++; if (tx_en_sig !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL mid_done_ignored en=%0b count=%0d empty=%0b exp=0/0/1", tx_en_sig, count, empty); end
  endtask

  task automatic test_wrap_stream();
    bq_t src, got;
    int gb; bit to;
    do_reset();
    tx_done = 1;
    tick();
    tx_done = 0;
    tick();
    n_cmp++; if (tx_en_sig !== 1'b0 || count !== 5'd0 || tx_data !== 8'h00) begin
      n_bad++; $display("FAIL idle_done en=%0b count=%0d data=%h exp=0/0/00", tx_en_sig, count, tx_data); end
    src = {};
    for (int i = 0; i < 40; i++) src.push_back(8'(i));
    stream(src, 40, 3, got, gb, to);
    n_cmp++; if (to || got.size() != 40) begin n_bad++; $display("FAIL wrap_n got=%0d exp=40", got.size()); end
    else begin
      for (int i = 0; i < 40; i++) begin
        n_cmp++; if (got[i] !== 8'(i)) begin n_bad++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got[i], 8'(i)); end
      end
    end
    n_cmp++; if (overflow !== 1'b0 || count !== 5'd0) begin n_bad++; $display("FAIL wrap_end ovf=%0b count=%0d exp=0/0", overflow, count); end
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_full_overflow();
    test_simul_push_pop();
    test_reset_mid_send();
    test_wrap_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
